// File: rtl/async_fifo_if.sv
// Producer/consumer handshake bundle for the single-clock FIFO.
// The master drives requests; the slave (FIFO) returns data and status.
interface async_fifo_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             full_flag;
  logic             empty_flag;

  modport master (
    output wr_en,
    output wr_data,
    output rd_en,
    input  rd_data,
    input  full_flag,
    input  empty_flag
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  rd_en,
    output rd_data,
    output full_flag,
    output empty_flag
  );
endinterface

// File: rtl/async_fifo_top.sv
// Single-clock FIFO: register-file memory, write pointer/full logic,
// and read pointer/empty logic with a registered read port.
module async_fifo_top #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
) (
  input  logic          clk,
  input  logic          rst,
  async_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR:0]    r_wr_ptr;
  logic [ADDR:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_rd_data;

  logic [ADDR-1:0]  w_wr_add;
  logic [ADDR-1:0]  rd_add;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign w_wr_add = r_wr_ptr[ADDR-1:0];
  assign rd_add   = r_rd_ptr[ADDR-1:0];

  // Extra MSB separates a full lap from an empty one.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR] != r_rd_ptr[ADDR]) &&
                   (w_wr_add == rd_add);

  assign w_wr_ok = bus.wr_en && !w_full;
  assign w_rd_ok = bus.rd_en && !w_empty;

  assign bus.full_flag  = w_full;
  assign bus.empty_flag = w_empty;
  assign bus.rd_data    = r_rd_data;

  always_ff @(posedge clk) begin
    if (rst && w_wr_ok) begin
      r_mem[w_wr_add] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
    end else if (w_wr_ok) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else if (w_rd_ok) begin
      r_rd_ptr  <= r_rd_ptr + 1'b1;
      r_rd_data <= r_mem[rd_add];
    end
  end
endmodule

// File: tb/tb_async_fifo_top.sv
// Bench for async_fifo_top: queue model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_async_fifo_top;
  logic clk = 1'b0;
  logic rst = 1'b0;

  async_fifo_if #(.WIDTH(8)) bus ();

  async_fifo_top #(.WIDTH(8), .ADDR(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a queue of stored words and a count of reads since reset.
  logic [7:0] q[$];
  logic [7:0] m_rd;
  int         m_rdcnt;
  bit         m_valid = 0;

  always @(posedge clk) begin
    bit wok, rok;
    if (!rst) begin
      q.delete();
      m_rd    = 8'h00;
      m_rdcnt = 0;
      m_valid = 1;
    end else if (m_valid) begin
      wok = bus.wr_en && (q.size() < 16);
      rok = bus.rd_en && (q.size() > 0);
      if (rok) begin
        m_rd = q.pop_front();
        m_rdcnt++;
      end
      if (wok) q.push_back(bus.wr_data);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_rd_data", {24'd0, bus.rd_data}, {24'd0, m_rd});
      chk("cmp_empty", {31'd0, bus.empty_flag}, {31'd0, q.size() == 0});
      chk("cmp_full", {31'd0, bus.full_flag}, {31'd0, q.size() == 16});
      chk("cmp_rd_add", {28'd0, dut.rd_add}, m_rdcnt % 16);
    end
  end

  task automatic cyc(input logic we, input logic [7:0] wd,
                     input logic re);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fval(input int i);
    logic [7:0] v;
    v = (i < 15) ? 8'((i + 1) * 17) : 8'hCD;
    return v;
  endfunction

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    rst = 1'b0;
    cyc(0, 8'h00, 0);
    rst = 1'b1;
    chk("rst_rd_data", {24'd0, bus.rd_data}, 32'h00);
    chk("rst_empty", {31'd0, bus.empty_flag}, 32'd1);
    chk("rst_full", {31'd0, bus.full_flag}, 32'd0);
    chk("rst_rd_add", {28'd0, dut.rd_add}, 32'd0);

    // Fill
    for (int i = 0; i < 16; i++) begin
      cyc(1, fval(i), 0);
      if (i == 0) chk("fill_empty_drop", {31'd0, bus.empty_flag}, 32'd0);
      if (i == 14) chk("fill_not_full15", {31'd0, bus.full_flag}, 32'd0);
    end
    chk("fill_full", {31'd0, bus.full_flag}, 32'd1);
    cyc(1, 8'hBC, 0);
    chk("fill_17_full", {31'd0, bus.full_flag}, 32'd1);

    // Drain
    for (int i = 0; i < 16; i++) begin
      chk("drain_add", {28'd0, dut.rd_add}, i);
      cyc(0, 8'h00, 1);
      chk("drain_data", {24'd0, bus.rd_data}, {24'd0, fval(i)});
    end
    chk("drain_empty", {31'd0, bus.empty_flag}, 32'd1);
    cyc(0, 8'h00, 1);
    chk("drain_17_data", {24'd0, bus.rd_data}, 32'hCD);
    chk("drain_17_add", {28'd0, dut.rd_add}, 32'd0);

    // Wrap
    for (int i = 1; i <= 7; i++) cyc(1, 8'(i * 16), 0);
    for (int i = 1; i <= 7; i++) begin
      chk("wrap_add", {28'd0, dut.rd_add}, i - 1);
      cyc(0, 8'h00, 1);
      chk("wrap_data", {24'd0, bus.rd_data}, i * 16);
    end
    chk("wrap_empty", {31'd0, bus.empty_flag}, 32'd1);
    chk("wrap_full", {31'd0, bus.full_flag}, 32'd0);

    // Simultaneous, partially filled
    for (int i = 0; i < 8; i++) cyc(1, 8'hA0 + 8'(i), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'hB0 + 8'(i), 1);
      chk("sim_data", {24'd0, bus.rd_data}, 32'hA0 + i);
    end
    for (int i = 0; i < 8; i++) cyc(1, 8'hC0 + 8'(i), 0);
    chk("sim_full", {31'd0, bus.full_flag}, 32'd1);
    cyc(1, 8'hEE, 1);
    chk("sim_full_rd", {24'd0, bus.rd_data}, 32'hA4);
    chk("sim_full_drop", {31'd0, bus.full_flag}, 32'd0);
    for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1);
    chk("sim_last", {24'd0, bus.rd_data}, 32'hC7);
    chk("sim_empty", {31'd0, bus.empty_flag}, 32'd1);
    cyc(1, 8'h5A, 1);
    chk("sim_empty_hold", {24'd0, bus.rd_data}, 32'hC7);
    chk("sim_empty_wr", {31'd0, bus.empty_flag}, 32'd0);
    cyc(0, 8'h00, 1);
    chk("sim_empty_rd", {24'd0, bus.rd_data}, 32'h5A);

    // Mid-operation reset
    for (int i = 0; i < 5; i++) cyc(1, 8'h60 + 8'(i), 0);
    rst = 1'b0;
    cyc(1, 8'h99, 1);
    rst = 1'b1;
    chk("mrst_empty", {31'd0, bus.empty_flag}, 32'd1);
    chk("mrst_data", {24'd0, bus.rd_data}, 32'h00);
    cyc(1, 8'h77, 0);
    cyc(0, 8'h00, 1);
    chk("mrst_rd", {24'd0, bus.rd_data}, 32'h77);
    chk("mrst_end_empty", {31'd0, bus.empty_flag}, 32'd1);

    cyc(0, 8'h00, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
